perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of counter channels, legal range 1..8.
REQ-002 Parameter CNT_W, default 64: counter width in bits, legal range 33..64.
REQ-003 Port clk, input, 1: sole clock; every register updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port event_i, input, NUM_CH: per-channel increment strobe, level-sampled each cycle; bit 0 is ignored because channel 0 counts cycles.
REQ-006 Port wr_en, input, 1: register write strobe.
REQ-007 Port addr, input, 5: register address, used for both writes and reads.
REQ-008 Port wdata, input, 32: write data.
REQ-009 Port rd_en, input, 1: register read strobe.
REQ-010 Port rdata, output, 32: read data, registered.
REQ-011 Port rd_valid, output, 1: high for exactly one cycle while rdata is valid.
REQ-012 Port ovf_irq, output, 1: OR of all OVF bits that are also set in IRQ_EN.

Function
REQ-013 Register map:
- 0x00 CTRL: bits [NUM_CH-1:0], per-channel enable, read/write.
- 0x01 OVF: sticky overflow flags; write-1-to-clear.
- 0x02 IRQ_EN: read/write.
- 0x03 CMD: write-only. bit0 = snapshot all channels; bit1 = clear all channels.
- 0x08+2i: SNAP_LO of channel i, read-only.
- 0x09+2i: SNAP_HI of channel i, read-only; bits above CNT_W-32 read 0.
REQ-014 Channel 0 SHALL increment every cycle while its CTRL bit is set.
REQ-015 Channel i>0 SHALL increment by 1 in the cycle after event_i[i]=1 is sampled with its CTRL bit set.
REQ-016 Counter arithmetic is modulo 2^CNT_W. On the increment from all-ones to 0, OVF[i] SHALL be set in the same cycle.
REQ-017 A CMD snapshot SHALL copy the value that all live counters hold at that write edge into the snapshot registers, atomically across channels.
REQ-018 A read issued with rd_en SHALL return data on rdata, with rd_valid=1, exactly one cycle later. Reads of write-only or unmapped addresses return 0. Back-to-back reads are allowed, one per cycle.
REQ-019 Writes to read-only or unmapped addresses SHALL have no effect.
REQ-020 Simultaneous clear and increment: clear wins, and the counter becomes 0.
REQ-021 Simultaneous overflow set and W1C of the same OVF bit: set wins.
REQ-022 Simultaneous snapshot and clear in one CMD write: the snapshot captures the pre-clear values.
REQ-023 Clear SHALL NOT affect OVF, CTRL, IRQ_EN or the snapshot registers.
REQ-024 rdata holds its last value when rd_valid=0.
REQ-025 wr_en and rd_en in the same cycle are both honoured. A read of the register being written returns the pre-write value.

Reset
REQ-026 Reset SHALL asynchronously clear to 0: all counters, snapshots, CTRL, OVF, IRQ_EN, rdata, rd_valid and ovf_irq.
REQ-027 Reset asserted mid-operation aborts any pending read: rd_valid=0 and no delayed response after release.
REQ-028 Counting starts only after software sets CTRL bits; after reset all channels are disabled.

Structure
REQ-029 Package perf_counter_pkg SHALL hold:
- the address constants ADDR_CTRL, ADDR_OVF, ADDR_IRQ_EN, ADDR_CMD, ADDR_SNAP_BASE;
- the CMD bit indices;
- the maximum channel count.
REQ-030 Sub-module perf_counter_channel (parameter CNT_W) SHALL contain one live counter, its snapshot register and its wrap detection. perf_counter_bank instantiates NUM_CH copies plus the register and read logic.

Verification
REQ-031 Reset release, write CTRL=0x1, idle 10 cycles, write CMD=0x1, read 0x08 -> rdata equals the cycles elapsed between the CTRL write and the snapshot edge (10 idle cycles plus intervening write cycles); read 0x09 -> rdata=0.
REQ-032 Enable channel 2, pulse event_i[2] on 5 non-contiguous cycles and hold event_i[1] high with CTRL[1]=0, snapshot, then read -> channel 2 SNAP_LO=5 and channel 1 SNAP_LO=0.
REQ-033 Build with CNT_W=33, enable channel 0, run 2^33 cycles (forced or long sim), with IRQ_EN=0x1 -> counter wraps to 0, OVF=0x1 and ovf_irq=1. Write OVF=0x1 -> ovf_irq=0 next cycle.
REQ-034 In the same cycle write CMD=0x3 and pulse event_i[1] on enabled channel 1 holding value 7 -> SNAP_LO=7; next-cycle live value 0; later snapshot reads 0.
REQ-035 Issue rd_en on 0x00 and assert rst in the following cycle -> rd_valid stays 0 during and after reset, and rdata=0.
REQ-036 Back-to-back reads of 0x01, 0x02 and 0x1F on consecutive cycles -> three consecutive rd_valid pulses in order, with 0x1F returning 0.

Source files
------------

// File: rtl/perf_counter_pkg.sv
// rtl/perf_counter_pkg.sv - register map and command constants for the performance counter bank
package perf_counter_pkg;

  localparam logic [4:0] ADDR_CTRL      = 5'h00;
  localparam logic [4:0] ADDR_OVF       = 5'h01;
  localparam logic [4:0] ADDR_IRQ_EN    = 5'h02;
  localparam logic [4:0] ADDR_CMD       = 5'h03;
  localparam logic [4:0] ADDR_SNAP_BASE = 5'h08;

  localparam int CMD_SNAP_BIT = 0;
  localparam int CMD_CLR_BIT  = 1;

  localparam int MAX_CH = 8;

endpackage

// File: rtl/perf_counter_channel.sv
// rtl/perf_counter_channel.sv - one live counter with snapshot register and wrap detection
module perf_counter_channel #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  input  logic             snapshot,
  output logic [CNT_W-1:0] snap,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count;

  // A clear suppresses the increment, so it cannot be counted as a wrap either.
  assign wrap = inc && !clear && (&count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

  // Captures the value held before this edge's clear or increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
    end else if (snapshot) begin
      snap <= count;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of cycle/event counters with atomic snapshot and register access
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              wr_en,
  input  logic [4:0]        addr,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  output logic [31:0]       rdata,
  output logic              rd_valid,
  output logic              ovf_irq
);

  logic [NUM_CH-1:0] ctrl;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] ovf_clr;
  logic [CNT_W-1:0]  snap_val [NUM_CH];
  logic              wr_cmd;
  logic              snap_cmd;
  logic              clr_cmd;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign wr_cmd      = wr_en && (addr == ADDR_CMD);
  assign snap_cmd    = wr_cmd && wdata[CMD_SNAP_BIT];
  assign clr_cmd     = wr_cmd && wdata[CMD_CLR_BIT];
  assign ovf_clr     = (wr_en && (addr == ADDR_OVF)) ? wdata[NUM_CH-1:0] : '0;
  assign ovf_irq     = |(ovf & irq_en);
  assign unused_bits = ^wdata[31:NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    // Channel 0 counts cycles, so its event strobe is ignored.
    assign inc[i] = ctrl[i] & ((i == 0) | event_i[i]);

    perf_counter_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[i]),
      .clear    (clr_cmd),
      .snapshot (snap_cmd),
      .snap     (snap_val[i]),
      .wrap     (wrap[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (addr == ADDR_CTRL) begin
      rd_mux = 32'(ctrl);
    end else if (addr == ADDR_OVF) begin
      rd_mux = 32'(ovf);
    end else if (addr == ADDR_IRQ_EN) begin
      rd_mux = 32'(irq_en);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_SNAP_BASE + 5'(2 * i)) begin
        rd_mux = snap_val[i][31:0];
      end
      if (addr == ADDR_SNAP_BASE + 5'(2 * i + 1)) begin
        rd_mux = 32'(snap_val[i][CNT_W-1:32]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      irq_en   <= '0;
      ovf      <= '0;
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en && (addr == ADDR_CTRL)) begin
        ctrl <= wdata[NUM_CH-1:0];
      end
      if (wr_en && (addr == ADDR_IRQ_EN)) begin
        irq_en <= wdata[NUM_CH-1:0];
      end
      // A wrap in the same cycle as a write-1-to-clear keeps the flag set.
      ovf      <= (ovf & ~ovf_clr) | wrap;
      rd_valid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed self-checking bench with a read-response scoreboard
module tb_perf_counter_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 33;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] event_i;
  logic              wr_en;
  logic [4:0]        addr;
  logic [31:0]       wdata;
  logic              rd_en;
  logic [31:0]       rdata;
  logic              rd_valid;
  logic              ovf_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .event_i  (event_i),
    .wr_en    (wr_en),
    .addr     (addr),
    .wdata    (wdata),
    .rd_en    (rd_en),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .ovf_irq  (ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every rd_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst === 1'b0 && rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rd_spurious", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.tag, rdata, mon_e.value);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    sb.push_back('{tag, exp});
    tick();
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    event_i = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    wdata   = '0;
    #12;
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ovf_irq", {31'd0, ovf_irq}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    rd(5'h00, 32'd0, "reset_ctrl");
    rd(5'h01, 32'd0, "reset_ovf");
    rd(5'h02, 32'd0, "reset_irq_en");
    repeat (5) tick();
    wr(5'h03, 32'h1);
    rd(5'h08, 32'd0, "disabled_snap0");

    // Cycle counter: 10 idle edges between the CTRL write and the snapshot edge.
    wr(5'h00, 32'h1);
    repeat (10) tick();
    wr(5'h03, 32'h1);
    rd(5'h08, 32'd10, "cycle_snap_lo");
    rd(5'h09, 32'd0, "cycle_snap_hi");
    rd(5'h03, 32'd0, "cmd_write_only");
    wr(5'h08, 32'hFFFF);
    rd(5'h08, 32'd10, "snap_read_only");
    wr(5'h1E, 32'hF);
    rd(5'h1E, 32'd0, "unmapped");

    // Read and write of CTRL in one cycle returns the old value.
    addr  = 5'h00;
    wdata = 32'h4;
    wr_en = 1'b1;
    rd_en = 1'b1;
    sb.push_back('{"rw_same_cycle", 32'h1});
    tick();
    check("rw_same_cycle_valid", {31'd0, rd_valid}, 32'd1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rd(5'h00, 32'h4, "ctrl_after_rw");

    // Channel 2 counts events; channel 1 is disabled while its event is held.
    event_i[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      event_i[2] = 1'b1;
      tick();
      event_i[2] = 1'b0;
      tick();
    end
    event_i = '0;
    wr(5'h03, 32'h1);
    rd(5'h0C, 32'd5, "ch2_snap_lo");
    rd(5'h0A, 32'd0, "ch1_snap_lo_disabled");
    rd(5'h0D, 32'd0, "ch2_snap_hi");

    // Snapshot and clear together, with a colliding increment on channel 1.
    wr(5'h00, 32'h2);
    for (int i = 0; i < 7; i++) begin
      event_i[1] = 1'b1;
      tick();
    end
    event_i    = '0;
    addr       = 5'h03;
    wdata      = 32'h3;
    wr_en      = 1'b1;
    event_i[1] = 1'b1;
    tick();
    wr_en   = 1'b0;
    event_i = '0;
    rd(5'h0A, 32'd7, "snapclr_ch1");
    rd(5'h0C, 32'd5, "snapclr_ch2");
    wr(5'h03, 32'h1);
    rd(5'h0A, 32'd0, "after_clr_ch1");
    rd(5'h0C, 32'd0, "after_clr_ch2");
    rd(5'h00, 32'h2, "ctrl_after_clr");

    // Overflow: channel 0 held at all-ones so the next enabled edge wraps.
    wr(5'h02, 32'h1);
    wr(5'h00, 32'h1);
    check("ovf_irq_before_wrap", {31'd0, ovf_irq}, 32'd0);
    force dut.gen_ch[0].u_ch.count = '1;
    wr(5'h01, 32'h1);
    check("ovf_set_wins", {31'd0, ovf_irq}, 32'd1);
    wr(5'h00, 32'h0);
    release dut.gen_ch[0].u_ch.count;
    rd(5'h01, 32'h1, "ovf_sticky");
    wr(5'h02, 32'h0);
    check("ovf_irq_masked", {31'd0, ovf_irq}, 32'd0);
    wr(5'h02, 32'h1);
    check("ovf_irq_unmasked", {31'd0, ovf_irq}, 32'd1);
    wr(5'h01, 32'h1);
    check("ovf_w1c_irq", {31'd0, ovf_irq}, 32'd0);
    rd(5'h01, 32'h0, "ovf_cleared");

    // Reset lands while a read response is in flight.
    wr(5'h00, 32'h6);
    addr  = 5'h00;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    rst   = 1'b1;
    #1;
    check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    end
    rd(5'h00, 32'd0, "post_rst_ctrl");

    // Back-to-back reads, one per cycle.
    wr(5'h02, 32'h5);
    rd_en = 1'b1;
    addr  = 5'h01;
    sb.push_back('{"b2b_ovf", 32'h0});
    tick();
    check("b2b_1_valid", {31'd0, rd_valid}, 32'd1);
    addr = 5'h02;
    sb.push_back('{"b2b_irq_en", 32'h5});
    tick();
    check("b2b_2_valid", {31'd0, rd_valid}, 32'd1);
    addr = 5'h1F;
    sb.push_back('{"b2b_unmapped", 32'h0});
    tick();
    check("b2b_3_valid", {31'd0, rd_valid}, 32'd1);
    rd_en = 1'b0;
    tick();
    check("b2b_end_valid", {31'd0, rd_valid}, 32'd0);

    rd(5'h02, 32'h5, "hold_src");
    addr = 5'h00;
    tick();
    tick();
    check("rdata_hold", rdata, 32'h5);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
